// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder: size encodings, bus width,
// and the packed response-queue entry width.
`ifndef DSR_RESP_ENTRY_W
`define DSR_RESP_ENTRY_W(cnt_w) (1 + 32 + (cnt_w))
`endif

package data_sram_responder_pkg;
  typedef enum logic [1:0] {
    SRAM_SIZE_B = 2'd0,
    SRAM_SIZE_H = 2'd1,
    SRAM_SIZE_W = 2'd2
  } sram_size_e;

  localparam int DATA_W = 32;

  // Countdown must hold LAT-1 plus up to 3 extra random-delay cycles.
  function automatic int resp_cnt_w(input int lat);
    return $clog2(lat + 4);
  endfunction
endpackage

// File: rtl/data_sram_responder_resp_queue.sv
// In-order circular response FIFO; each entry counts down to zero and the
// head is ready to retire once its count has expired.
module data_sram_responder_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_wr,
  input  logic [31:0]       i_data,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic              i_pop,
  output logic [CW-1:0]     o_count,
  output logic              o_head_rdy,
  output logic              o_head_wr,
  output logic [31:0]       o_head_data
);
  localparam int EW    = `DSR_RESP_ENTRY_W(CNT_W);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0]    r_ent [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CW-1:0]    r_count;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= nxt(r_tail);
      if (i_pop)  r_head <= nxt(r_head);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale entries keep counting harmlessly; only the valid region is observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (r_ent[i][CNT_W-1:0] != '0) r_ent[i][CNT_W-1:0] <= r_ent[i][CNT_W-1:0] - 1'b1;
    if (i_push) r_ent[r_tail] <= {i_wr, i_data, i_cnt};
  end

  assign o_count     = r_count;
  assign o_head_rdy  = (r_count != '0) && (r_ent[r_head][CNT_W-1:0] == '0);
  assign o_head_wr   = r_ent[r_head][EW-1];
  assign o_head_data = r_ent[r_head][CNT_W +: 32];
endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM-like memory responder: word array plus in-order delayed responses.
// Optional macro RANDOM_DELAY_EN adds LFSR-driven extra latency and accept stalls.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int OUTSTANDING = 2,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam int CNT_W = resp_cnt_w(LAT);
  localparam int QCW   = $clog2(OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic              r_data_ok;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_idx;
  logic              w_accept, w_gate, w_head_rdy, w_head_wr;
  logic [QCW-1:0]    w_count;
  logic [CNT_W-1:0]  w_cnt_init;
  logic [31:0]       w_head_data;
  logic              w_unused_ok;

`ifdef RANDOM_DELAY_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_cnt_init = CNT_INIT + {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};
  assign w_gate     = (r_lfsr[4:2] != 3'b000);
`else
  assign w_cnt_init = CNT_INIT;
  assign w_gate     = 1'b1;
`endif

  // Upper address bits alias; byte offset and size never affect the word returned.
  assign w_idx       = data_sram_addr[ADDR_W+1:2];
  assign w_unused_ok = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};

  // Full queue refuses even in its dequeue cycle: count is pre-dequeue.
  assign data_sram_addr_ok = !reset && (w_count < QCW'(OUTSTANDING)) && w_gate;
  assign w_accept          = data_sram_req && data_sram_addr_ok;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (w_accept && data_sram_wr && data_sram_wstrb[b])
        r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
  end

  data_sram_responder_resp_queue #(
    .DEPTH (OUTSTANDING),
    .CNT_W (CNT_W),
    .CW    (QCW)
  ) u_q (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_accept),
    .i_wr        (data_sram_wr),
    .i_data      (r_mem[w_idx]),
    .i_cnt       (w_cnt_init),
    .i_pop       (w_head_rdy),
    .o_count     (w_count),
    .o_head_rdy  (w_head_rdy),
    .o_head_wr   (w_head_wr),
    .o_head_data (w_head_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= w_head_rdy;
      r_rdata   <= (w_head_rdy && !w_head_wr) ? w_head_data : 32'h0;
    end
  end

  assign data_sram_data_ok = r_data_ok;
  assign data_sram_rdata   = r_rdata;
endmodule
